// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: holds M, {C,A,Q} and the iteration counter,
// executing RESET/ADD/SHIFT/DECREMENT commands issued by the sequencer.
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic [WIDTH-1:0]             multiplicand,
    input  logic [WIDTH-1:0]             multiplier,
    input  logic                         RESET,
    input  logic                         ADD,
    input  logic                         SHIFT,
    input  logic                         DECREMENT,
    output logic [2*WIDTH:0]             register,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic [2*WIDTH-1:0]           product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  m_r;
    logic [2*WIDTH:0]  reg_r;
    logic [2*WIDTH:0]  reg_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [WIDTH:0]    sum_s;

    // Add (carry in the MSB) and optional right shift, resolved in one cycle.
    always_comb begin
        sum_s     = reg_r[2*WIDTH:WIDTH];
        reg_nxt_s = reg_r;
        if (ADD) begin
            sum_s = {1'b0, reg_r[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
        end else begin
            sum_s = reg_r[2*WIDTH:WIDTH];
        end
        if (RESET) begin
            reg_nxt_s = {1'b0, {WIDTH{1'b0}}, multiplier};
        end else if (SHIFT) begin
            reg_nxt_s = {1'b0, sum_s, reg_r[WIDTH-1:1]};
        end else if (ADD) begin
            reg_nxt_s = {sum_s, reg_r[WIDTH-1:0]};
        end else begin
            reg_nxt_s = reg_r;
        end
    end

    // Iteration counter: reload on RESET, saturating decrement otherwise.
    always_comb begin
        count_nxt_s = count_r;
        if (RESET) begin
            count_nxt_s = COUNT_LOAD;
        end else if (DECREMENT && (count_r != COUNT_ZERO)) begin
            count_nxt_s = count_r - COUNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers; operands are captured only on RESET.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_r     <= {WIDTH{1'b0}};
            reg_r   <= {(2*WIDTH+1){1'b0}};
            count_r <= COUNT_ZERO;
        end else begin
            if (RESET) begin
                m_r <= multiplicand;
            end
            reg_r   <= reg_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign register = reg_r;
    assign count    = count_r;
    assign product  = reg_r[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Scoreboard bench for multiplier_datapath: an arithmetic reference model queues
// the expected state per cycle; a monitor compares once the DUT has updated.
module tb_multiplier_datapath;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          RESET, ADD, SHIFT, DECREMENT;
    logic [2*W:0]  register;
    logic [3:0]    count;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W:0]   r;
        logic [3:0]     c;
        bit             chk;
        logic [2*W-1:0] p;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int mdl_m, mdl_ca, mdl_q, mdl_cnt;

    multiplier_datapath #(.WIDTH(W)) dut (
        .clk(clk), .n_reset(n_reset),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .RESET(RESET), .ADD(ADD), .SHIFT(SHIFT), .DECREMENT(DECREMENT),
        .register(register), .count(count), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one command cycle and queue the state expected after its edge.
    task automatic step(input bit rst, input bit add, input bit sh, input bit dec,
                        input int mc, input int mp, input bit chk, input int prod);
        exp_t e;
        int   s, full;
        @(negedge clk);
        RESET = rst; ADD = add; SHIFT = sh; DECREMENT = dec;
        multiplicand = mc[W-1:0];
        multiplier   = mp[W-1:0];
        if (rst) begin
            mdl_m = mc & 255; mdl_ca = 0; mdl_q = mp & 255; mdl_cnt = W;
        end else begin
            s = add ? ((mdl_ca & 255) + mdl_m) : mdl_ca;
            if (sh) begin
                full   = ((s << W) | mdl_q) >> 1;
                mdl_ca = full >> W;
                mdl_q  = full & 255;
            end else begin
                mdl_ca = s;
            end
            if (dec && mdl_cnt > 0) mdl_cnt--;
        end
        e.r = 17'((mdl_ca << W) | mdl_q);
        e.c = 4'(mdl_cnt);
        e.chk = chk;
        e.p = 16'(prod);
        sb.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    // Eight sequencer-style iterations; the final one also checks product == a*b.
    task automatic seq8(input int a, input int b, input bit junk);
        for (int i = 0; i < W; i++) begin
            step(1'b0, mdl_q[0], 1'b1, 1'b1,
                 junk ? int'($urandom) : a, junk ? int'($urandom) : b,
                 i == W - 1, a * b);
        end
    endtask

    task automatic run(input int a, input int b, input bit junk);
        step(1'b1, 1'b0, 1'b0, 1'b0, a, b, 1'b0, 0);
        seq8(a, b, junk);
    endtask

    task automatic async_reset();
        idle();
        repeat (3) @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        check("async_reg", 32'(register), 32'd0);
        check("async_cnt", 32'(count), 32'd0);
        check("async_prod", 32'(product), 32'd0);
        RESET = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0;
        mdl_m = 0; mdl_ca = 0; mdl_q = 0; mdl_cnt = 0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    // Monitor: the DUT updates every edge, so each queued entry is compared
    // shortly after the edge it describes.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("register", 32'(register), 32'(e.r));
            check("count", 32'(count), 32'(e.c));
            check("product_field", 32'(product), 32'(e.r[2*W-1:0]));
            if (e.chk) check("product_final", 32'(product), 32'(e.p));
        end
    end

    initial begin
        int a, b;
        n_reset = 1'b0;
        RESET = 1'b1; ADD = 1'b1; SHIFT = 1'b1; DECREMENT = 1'b1;
        multiplicand = 8'hA5; multiplier = 8'h3C;
        #2;
        check("rst_reg", 32'(register), 32'd0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_prod", 32'(product), 32'd0);
        #10;
        RESET = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0;
        mdl_m = 0; mdl_ca = 0; mdl_q = 0; mdl_cnt = 0;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) idle();

        run(13, 11, 1'b0);
        run(255, 255, 1'b1);
        run(0, 200, 1'b1);
        run(200, 0, 1'b1);

        // Saturation at zero, then ADD alone.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5, 8'h96, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);

        // RESET mid-run with every other command asserted.
        step(1'b1, 1'b0, 1'b0, 1'b0, 100, 77, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, mdl_q[0], 1'b1, 1'b1, 0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 0);
        seq8(8'h5A, 8'hC3, 1'b1);

        // Asynchronous reset in the middle of a run.
        step(1'b1, 1'b0, 1'b0, 1'b0, 77, 99, 1'b0, 0);
        repeat (3) step(1'b0, mdl_q[0], 1'b1, 1'b1, 0, 0, 1'b0, 0);
        async_reset();
        repeat (2) idle();

        for (int k = 0; k < 12; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run(a, b, 1'b1);
        end

        for (int k = 0; k < 150; k++) begin
            step($urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom), int'($urandom), 1'b0, 0);
        end

        idle();
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
